// File: rtl/bp_fe_queue_buffer_if.sv
// Handshake bundle between the fetch stage and bp_fe_queue_buffer:
// valid/ready on the enqueue side, valid/yumi on the dequeue side.
interface bp_fe_queue_buffer_if #(
  parameter int unsigned width_p = 128
);
  logic [width_p-1:0] data_i;
  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] data_o;
  logic               v_o;
  logic               yumi_i;

  modport master (
    output data_i, v_i, yumi_i,
    input  ready_o, data_o, v_o
  );

  modport slave (
    input  data_i, v_i, yumi_i,
    output ready_o, data_o, v_o
  );
endinterface

// File: rtl/bp_fe_queue_buffer.sv
// FE queue message buffer: circular FIFO with wrap-bit pointers and synchronous flush.
// Define BP_FE_QUEUE_ROLLBACK_EN to keep dequeued entries until commit_i, replayable via rollback_i.
module bp_fe_queue_buffer #(
  parameter int unsigned els_p   = 8,
  parameter int unsigned width_p = 128
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       clr_v_i,
  bp_fe_queue_buffer_if.slave        fe_if,
  input  logic                       commit_i,
  input  logic                       rollback_i,
  output logic [$clog2(els_p):0]     count_o
);

  localparam int unsigned idx_w_lp = $clog2(els_p);
  localparam int unsigned ptr_w_lp = idx_w_lp + 1;

  typedef logic [ptr_w_lp-1:0] ptr_t;

  logic [width_p-1:0] r_mem [els_p];

  ptr_t r_wptr;
  ptr_t r_rptr;
  ptr_t w_wptr_n;
  ptr_t w_rptr_n;
  ptr_t w_cptr;
  ptr_t w_occ;

  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;
  logic w_rb;

  // Status comes only from registered pointers, so ready_o has no input path.
  assign w_occ   = r_wptr - w_cptr;
  assign w_full  = (w_occ == ptr_t'(els_p));
  assign w_empty = (r_wptr == r_rptr);

  assign w_enq = fe_if.v_i & ~w_full;
  assign w_deq = fe_if.yumi_i & ~w_empty & ~w_rb;

  assign fe_if.ready_o = ~w_full;
  assign fe_if.v_o     = ~w_empty;
  assign fe_if.data_o  = r_mem[r_rptr[idx_w_lp-1:0]];
  assign count_o       = w_occ;

`ifdef BP_FE_QUEUE_ROLLBACK_EN
  ptr_t r_cptr;
  ptr_t w_cptr_n;

  assign w_rb   = rollback_i;
  assign w_cptr = r_cptr;

  // Commit snapshots next-state rptr so a same-cycle dequeue is retired too.
  always_comb begin
    w_cptr_n = r_cptr;
    if (clr_v_i) begin
      w_cptr_n = '0;
    end else if (!rollback_i && commit_i) begin
      w_cptr_n = w_rptr_n;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cptr <= '0;
    end else begin
      r_cptr <= w_cptr_n;
    end
  end
`else
  logic w_unused_ctl;

  // Without rollback cptr always equals rptr, so it is an alias rather than a flop.
  assign w_rb         = 1'b0;
  assign w_cptr       = r_rptr;
  assign w_unused_ctl = commit_i ^ rollback_i;
`endif

  always_comb begin
    w_wptr_n = r_wptr;
    w_rptr_n = r_rptr;
    if (clr_v_i) begin
      w_wptr_n = '0;
      w_rptr_n = '0;
    end else begin
      if (w_enq) begin
        w_wptr_n = r_wptr + ptr_t'(1);
      end
      if (w_rb) begin
        w_rptr_n = w_cptr;
      end else if (w_deq) begin
        w_rptr_n = r_rptr + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= w_wptr_n;
      r_rptr <= w_rptr_n;
    end
  end

  // Storage is never reset or cleared; a flush suppresses the write instead.
  always_ff @(posedge clk_i) begin
    if (w_enq && !clr_v_i) begin
      r_mem[r_wptr[idx_w_lp-1:0]] <= fe_if.data_i;
    end
  end

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// Randomized scoreboard bench for bp_fe_queue_buffer (els_p=4) against a queue-based model.
// The rollback scenario is exercised when BP_FE_QUEUE_ROLLBACK_EN is defined.
module tb_bp_fe_queue_buffer;

  localparam int unsigned ELS = 4;
  localparam int unsigned W   = 16;

  typedef struct {
    bit             v;
    bit             rdy;
    int unsigned    cnt;
    logic [W-1:0]   d;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b1;
  logic                  clr_v = 1'b0;
  logic                  commit = 1'b0;
  logic                  rollback = 1'b0;
  logic [$clog2(ELS):0]  count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model: mq holds every occupied entry oldest-first; rd = dequeued-but-uncommitted.
  logic [W-1:0] mq[$];
  int unsigned  rd = 0;
  exp_t         exp_q[$];

  bp_fe_queue_buffer_if #(.width_p(W)) fe();

  bp_fe_queue_buffer #(.els_p(ELS), .width_p(W)) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .clr_v_i    (clr_v),
    .fe_if      (fe),
    .commit_i   (commit),
    .rollback_i (rollback),
    .count_o    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at a negedge, advance the model, queue the post-edge expectation.
  task automatic step(input logic v, input logic [W-1:0] d, input logic y,
                      input logic clr, input logic cm, input logic rb);
    bit   acc;
    bit   deq;
    exp_t e;
    fe.v_i    = v;
    fe.data_i = d;
    fe.yumi_i = y;
    clr_v     = clr;
    commit    = cm;
    rollback  = rb;
    acc = v && (mq.size() < ELS);
    deq = y && (rd < mq.size());
    if (!reset_n || clr) begin
      mq.delete();
      rd = 0;
    end else begin
`ifdef BP_FE_QUEUE_ROLLBACK_EN
      if (rb) begin
        rd = 0;
      end else begin
        if (deq) rd++;
        if (cm) begin
          for (int i = 0; i < int'(rd); i++) void'(mq.pop_front());
          rd = 0;
        end
      end
`else
      if (deq) void'(mq.pop_front());
`endif
      if (acc) mq.push_back(d);
    end
    e.v   = (rd < mq.size());
    e.rdy = (mq.size() < ELS);
    e.cnt = mq.size();
    e.d   = e.v ? mq[rd] : '0;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares DUT outputs shortly after every rising edge with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("v_o",     W'(fe.v_o),     W'(e.v));
        chk("ready_o", W'(fe.ready_o), W'(e.rdy));
        chk("count_o", W'(count),      W'(e.cnt));
        if (e.v) chk("data_o", fe.data_o, e.d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r;
    fe.v_i    = 1'b0;
    fe.data_i = '0;
    fe.yumi_i = 1'b0;

    // Asynchronous reset must act before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    chk("rst_v_o",     W'(fe.v_o),     W'(0));
    chk("rst_ready_o", W'(fe.ready_o), W'(1));
    chk("rst_count_o", W'(count),      W'(0));
    @(negedge clk);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Fill to full, then a simultaneous dequeue/enqueue while full.
    for (int i = 0; i < 4; i++) step(1'b1, W'(16'hA0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, W'(16'hB0), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();

    // No bypass: entry appears one cycle after it is enqueued.
    step(1'b1, W'(16'hC0), 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // Enqueue/dequeue pairs around the pointer wrap.
    for (int i = 0; i < 6; i++) step(1'b1, W'(16'h30 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush with a same-cycle enqueue.
    for (int i = 0; i < 3; i++) step(1'b1, W'(16'h70 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, W'(16'hD0), 1'b1, 1'b1, 1'b1, 1'b1);
    idle();

`ifdef BP_FE_QUEUE_ROLLBACK_EN
    for (int i = 0; i < 3; i++) step(1'b1, W'(16'hE0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    // Randomized traffic, with occasional flush and commit/rollback.
    for (int i = 0; i < 400; i++) begin
      r = W'($urandom);
`ifdef BP_FE_QUEUE_ROLLBACK_EN
      step(($urandom % 4) != 0, r, ($urandom % 3) != 0, ($urandom % 40) == 0,
           ($urandom % 4) == 0, ($urandom % 12) == 0);
`else
      step(($urandom % 4) != 0, r, ($urandom % 3) != 0, ($urandom % 40) == 0,
           ($urandom % 3) == 0, ($urandom % 3) == 0);
`endif
    end

    // Reset mid-operation, asserted between clock edges.
    for (int i = 0; i < 3; i++) step(1'b1, W'(16'h90 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_v_o",     W'(fe.v_o),     W'(0));
    chk("midrst_ready_o", W'(fe.ready_o), W'(1));
    chk("midrst_count_o", W'(count),      W'(0));
    @(negedge clk);
    step(1'b1, W'(16'h99), 1'b1, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step(1'b1, W'(16'h55), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();

    @(posedge clk);
    #3;
    chk("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_fe_queue_buffer.md
BP_FE_QUEUE_BUFFER -- requirements
Module: bp_fe_queue_buffer

Interface
REQ-001 SHALL provide parameter els_p, default 8, entry count (power of two, >= 2).
REQ-002 SHALL provide parameter width_p, default 128, bits per entry (one FE queue message).
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports named clk_i and reset_n_i.
REQ-004 clk_i  input  1  rising-edge clock.
REQ-005 reset_n_i  input  1  asynchronous active-low reset.
REQ-006 clr_v_i  input  1  flush all entries (driven on any non-attaboy FE command).
REQ-007 data_i  input  width_p  enqueue payload from the fetch stage.
REQ-008 v_i  input  1  enqueue request.
REQ-009 ready_o  output  1  buffer can accept an entry this cycle.
REQ-010 data_o  output  width_p  head entry at the read pointer.
REQ-011 v_o  output  1  data_o holds a valid entry.
REQ-012 yumi_i  input  1  consumer takes head entry; legal only when v_o=1.
REQ-013 commit_i  input  1  retire all dequeued entries (rollback feature).
REQ-014 rollback_i  input  1  replay all uncommitted dequeued entries (rollback feature).
REQ-015 count_o  output  $clog2(els_p)+1  occupied entries.

Function
REQ-016 SHALL keep write pointer wptr, read pointer rptr and commit pointer cptr, each $clog2(els_p)+1 bits: the low bits index storage and the MSB is a wrap bit; all pointers increment modulo 2*els_p.
REQ-017 Full SHALL be (wptr - cptr) == els_p; empty-for-read SHALL be wptr == rptr.
REQ-018 ready_o SHALL equal ~full, derived only from registered state (no path from v_i, yumi_i, clr_v_i).
REQ-019 An enqueue SHALL occur when v_i & ready_o: the entry is written at wptr and wptr increments; v_i & ~ready_o SHALL NOT write or move pointers.
REQ-020 v_o SHALL equal (wptr != rptr); data_o SHALL equal storage[rptr]; no bypass, so an entry enqueued in cycle N is first visible on v_o/data_o in cycle N+1.
REQ-021 A dequeue SHALL occur when yumi_i & v_o and increments rptr; yumi_i & ~v_o SHALL be ignored.
REQ-022 count_o SHALL equal wptr - cptr.
REQ-023 When full, ready_o=0 SHALL hold even if a dequeue occurs the same cycle; ready_o rises the next cycle.
REQ-024 Enqueue and dequeue in the same cycle with 1 <= count <= els_p-1 SHALL leave count_o unchanged.
REQ-025 clr_v_i=1 SHALL set wptr=rptr=cptr=0 next cycle, overriding any same-cycle enqueue, dequeue, commit or rollback.
REQ-026 The cycle after clear SHALL give v_o=0, ready_o=1, count_o=0.
REQ-027 Storage contents SHALL NOT be cleared; data_o is don't-care whenever v_o=0.

Reset
REQ-028 On reset_n_i=0, SHALL asynchronously set wptr=rptr=cptr=0 and drive v_o=0, ready_o=1, count_o=0 without a clock edge.
REQ-029 Storage array SHALL NOT be reset.
REQ-030 Reset mid-operation SHALL discard all entries, in-flight or uncommitted.
REQ-031 Deassertion SHALL be synchronised externally; the first enqueue is accepted on the first rising edge after release.

Configuration
REQ-032 Macro BP_FE_QUEUE_ROLLBACK_EN SHALL select the rollback feature.
REQ-033 Defined, commit_i SHALL set cptr to the next-state rptr, so an entry dequeued in the same cycle is committed.
REQ-034 Defined, rollback_i SHALL set rptr=cptr next cycle; rollback wins over same-cycle commit_i and yumi_i, and both are ignored.
REQ-035 Defined, entries between cptr and rptr SHALL occupy space and count toward full and count_o.
REQ-036 Not defined, cptr SHALL track the next-state rptr every cycle, commit_i and rollback_i SHALL be ignored, and full/count use wptr - rptr.
REQ-037 Both ports SHALL exist in both builds.

Verification (els_p=4)
REQ-038 Reset, then 4 enqueues 0xA0..0xA3 with no yumi -> ready_o=0 after the 4th, count_o=4, v_o=1, data_o=0xA0.
REQ-039 From full, yumi_i and v_i=1 (0xB0) in the same cycle -> no write that cycle; next cycle ready_o=1, count_o=3, data_o=0xA1.
REQ-040 Enqueue 0xC0 into empty in cycle N -> v_o=0 in N, v_o=1 with data_o=0xC0 in N+1.
REQ-041 Drive 6 enqueue/dequeue pairs through wrap-around -> FIFO order kept, count_o never exceeds 4.
REQ-042 With 3 entries, clr_v_i together with v_i=1 (0xD0) -> next cycle count_o=0, v_o=0; 0xD0 never appears.
REQ-043 ROLLBACK_EN build: enqueue 0xE0..0xE2, dequeue 2, rollback_i -> data_o=0xE0, count_o=3; dequeue 1 + commit_i -> count_o=2.
